pulse_swallow_ctrl: RTL and testbench
=====================================

Name: pulse_swallow_ctrl

Overview:
Sequencing controller for the 2/3 dual-modulus frequency_divider. It drives the divider's modulus-control input so that a full output frame spans N = 2*P + S input clocks. P is the program count and S is the swallow count. The block sits beside the divider and counts the divider's output-cycle ticks. It accepts new (P, S) settings over a valid/ready port and applies them only at frame boundaries, so a frame is never torn.

Parameters:
CW, 8, width of the P/S configuration fields and of the internal counters.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset (reset=0 resets the block).
enable  input  1  run enable; low forces IDLE.
presc_tick  input  1  one-cycle pulse, synchronous to clk; marks completion of one divider output cycle.
cfg_valid  input  1  configuration offer.
cfg_ready  output  1  high when the shadow register is empty (equals !pend_v).
cfg_p  input  CW  program count P.
cfg_s  input  CW  swallow count S.
mc  output  1  modulus control to the divider: 1 = divide-by-3, 0 = divide-by-2. Registered.
frame_pulse  output  1  one-cycle pulse at each frame end. Registered.
p_count  output  CW  remaining program ticks in the current frame.
s_count  output  CW  remaining swallow ticks in the current frame.
cfg_err  output  1  one-cycle pulse when an offered configuration is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; mc=0, frame_pulse=0, cfg_err=0, p_count=0, s_count=0.
  - Active and pending registers cleared; pend_v=0, so cfg_ready=1.
- Configuration handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - Legal config: P>=1 and S<=P.
  - A legal config is stored in the pending register and pend_v is set.
  - An illegal config is consumed (the handshake completes), dropped, and cfg_err pulses high the next cycle. pend_v is unchanged.
- States: IDLE, SWALLOW (mc=1), MAIN (mc=0).
- Frame load:
  - Happens when state is IDLE with enable=1 and pend_v=1, or at a frame end.
  - If pend_v=1: the pending config moves to active and pend_v clears.
  - Load p_count=P_act and s_count=S_act.
  - Next state is SWALLOW if S_act>0, otherwise MAIN.
  - mc takes the new state's value in the same edge.
  - From IDLE with no config ever accepted, the block stays in IDLE.
- Counting, applied on each presc_tick=1 in SWALLOW or MAIN:
  - p_count decrements.
  - In SWALLOW, s_count also decrements. If s_count was 1, go to MAIN and set mc=0 on the same edge.
  - If p_count was 1, the frame ends:
    - frame_pulse=1 on the next cycle, for exactly one cycle.
    - A frame load is performed on the same edge, using pending if pend_v=1, else reloading the active config.
    - Frame end takes priority over the SWALLOW->MAIN transition. S=P is legal, so mc stays 1 for the entire frame.
- Latency: mc changes on the clk edge that samples presc_tick. The divider therefore sees the new modulus for its next cycle.
- Simultaneous events:
  - A config accepted on the same edge as a frame end goes to pending. It is applied at the following frame end, because the boundary uses pend_v as it was before the edge.
  - presc_tick in IDLE is ignored.
- enable=0 at any time:
  - Next edge: state=IDLE, mc=0, p_count=0, s_count=0, no frame_pulse.
  - Active and pending configs are retained.
  - On re-enable, a fresh frame load occurs with the active config when pend_v=0. This is the only IDLE load that does not need pend_v.
- Width rule: counters are CW bits unsigned and never decrement below 0. N is not computed in hardware.

Decomposition:
- Shared package: state encoding constants (IDLE/SWALLOW/MAIN), MC_DIV2=0, MC_DIV3=1, and the default CW.
- One natural sub-module, pulse_swallow_cfg_reg: the pending/active register pair, with the valid/ready logic and the legality check.
- The FSM and counters stay in the top module.

Test Plan:
1. Reset held low, then released with no cfg → mc=0, cfg_ready=1, state IDLE; presc_tick pulses produce no frame_pulse.
2. Offer P=4, S=1 with enable=1 and presc_tick every 3rd cycle → mc=1 for the first tick interval, then 0. frame_pulse one cycle after the 4th tick. Repeats every 4 ticks; p_count sequence 4,3,2,1,4.
3. Offer P=3, S=3 → mc stays 1 through the whole frame. Offer P=2, S=0 → mc stays 0 and frame_pulse comes every 2 ticks.
4. Offer P=0, S=0 and then P=2, S=5 → both are consumed with ready=1, cfg_err pulses once per offer, and the active config is unchanged.
5. Offer P=5, S=2 mid-frame while running P=4, S=1 → cfg_ready drops. The current frame completes with 4 ticks, then the P=5 frame starts and cfg_ready returns to 1.
6. Drop enable mid-SWALLOW, then restore it; separately, assert reset=0 mid-frame → enable loss forces IDLE and mc=0, and restart reloads the active config. Reset clears all outputs asynchronously, with no clk edge needed.

Source files
------------

// File: rtl/pulse_swallow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_swallow_ctrl_pkg
// Purpose  : Shared constants for the pulse-swallow sequencing controller:
//            state encoding, modulus-control levels and default field width.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_swallow_ctrl_pkg;

  // Default width of the P/S fields and the frame counters
  localparam int CW_DEFAULT = 8;

  // Controller states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SWALLOW = 2'd1;
  localparam logic [1:0] ST_MAIN    = 2'd2;

  // Modulus-control levels seen by the 2/3 divider
  localparam logic MC_DIV2 = 1'b0;
  localparam logic MC_DIV3 = 1'b1;

endpackage : pulse_swallow_ctrl_pkg
`default_nettype wire

// File: rtl/pulse_swallow_cfg_reg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_swallow_cfg_reg
// Purpose  : Pending/active (P, S) register pair with valid/ready intake and
//            legality check. A load request promotes the pending config to
//            active; load_p/load_s present whichever config a frame load uses.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_swallow_cfg_reg
  import pulse_swallow_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_p,
  input  logic [CW-1:0] cfg_s,
  input  logic          load,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          pend_v,
  output logic          act_v,
  output logic [CW-1:0] load_p,
  output logic [CW-1:0] load_s
);

  logic [CW-1:0] pend_p;
  logic [CW-1:0] pend_s;
  logic [CW-1:0] act_p;
  logic [CW-1:0] act_s;
  logic          accept;
  logic          legal;

  // Handshake completes whenever the shadow register is empty; legal means
  // at least one program tick and no more swallow ticks than program ticks.
  assign cfg_ready = !pend_v;
  assign accept    = cfg_valid && !pend_v;
  assign legal     = (cfg_p != '0) && (cfg_s <= cfg_p);

  // A frame load takes the pending config when present, else repeats active
  assign load_p = pend_v ? pend_p : act_p;
  assign load_s = pend_v ? pend_s : act_s;

  // Pending register: filled by a legal transfer, drained by a frame load.
  // Both cannot coincide because a transfer needs pend_v low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_v <= 1'b0;
      pend_p <= '0;
      pend_s <= '0;
    end else if (load && pend_v) begin
      pend_v <= 1'b0;
    end else if (accept && legal) begin
      pend_v <= 1'b1;
      pend_p <= cfg_p;
      pend_s <= cfg_s;
    end
  end

  // Active register: updated only when a frame load consumes the pending one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_v <= 1'b0;
      act_p <= '0;
      act_s <= '0;
    end else if (load && pend_v) begin
      act_v <= 1'b1;
      act_p <= pend_p;
      act_s <= pend_s;
    end
  end

  // Rejected offers are consumed and flagged for exactly one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= accept && !legal;
    end
  end

endmodule : pulse_swallow_cfg_reg
`default_nettype wire

// File: rtl/pulse_swallow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pulse_swallow_ctrl
// Purpose  : Drives the modulus control of a 2/3 divider so each frame spans
//            2*P + S input clocks: S divider cycles at /3 then P-S at /2.
//            Counts divider output ticks and applies new configs at frame
//            boundaries only.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_swallow_ctrl
  import pulse_swallow_ctrl_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          presc_tick,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_p,
  input  logic [CW-1:0] cfg_s,
  output logic          mc,
  output logic          frame_pulse,
  output logic [CW-1:0] p_count,
  output logic [CW-1:0] s_count,
  output logic          cfg_err
);

  logic [1:0]    state;
  logic [1:0]    next_state;
  logic [CW-1:0] p_next;
  logic [CW-1:0] s_next;
  logic          frame_end;
  logic          load;
  logic          mc_next;
  logic          pend_v;
  logic          act_v;
  logic [CW-1:0] load_p;
  logic [CW-1:0] load_s;

  pulse_swallow_cfg_reg #(
    .CW (CW)
  ) u_cfg (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_p     (cfg_p),
    .cfg_s     (cfg_s),
    .load      (load),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .pend_v    (pend_v),
    .act_v     (act_v),
    .load_p    (load_p),
    .load_s    (load_s)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      p_count     <= '0;
      s_count     <= '0;
      mc          <= MC_DIV2;
      frame_pulse <= 1'b0;
    end else begin
      state       <= next_state;
      p_count     <= p_next;
      s_count     <= s_next;
      mc          <= mc_next;
      frame_pulse <= frame_end;
    end
  end

  // Next state and counter values; a frame end reloads and overrides the
  // swallow-to-main step so an S=P frame stays at /3 throughout.
  always_comb begin
    next_state = state;
    p_next     = p_count;
    s_next     = s_count;
    frame_end  = 1'b0;
    load       = 1'b0;
    if (!enable) begin
      next_state = ST_IDLE;
      p_next     = '0;
      s_next     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Needs either a waiting config or a retained one from before
          if (pend_v || act_v) begin
            load = 1'b1;
          end
        end
        ST_SWALLOW, ST_MAIN: begin
          if (presc_tick) begin
            if (p_count == CW'(1)) begin
              frame_end = 1'b1;
              load      = 1'b1;
            end else begin
              if (p_count != '0) begin
                p_next = p_count - CW'(1);
              end
              if (state == ST_SWALLOW) begin
                if (s_count != '0) begin
                  s_next = s_count - CW'(1);
                end
                if (s_count <= CW'(1)) begin
                  next_state = ST_MAIN;
                end
              end
            end
          end
        end
        default: begin
          next_state = ST_IDLE;
          p_next     = '0;
          s_next     = '0;
        end
      endcase
      if (load) begin
        p_next     = load_p;
        s_next     = load_s;
        next_state = (load_s != '0) ? ST_SWALLOW : ST_MAIN;
      end
    end
  end

  // Modulus control follows the state being entered on the same edge
  always_comb begin
    mc_next = (next_state == ST_SWALLOW) ? MC_DIV3 : MC_DIV2;
  end

endmodule : pulse_swallow_ctrl
`default_nettype wire

// File: tb/tb_pulse_swallow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_swallow_ctrl
// Purpose  : Directed, table-driven bench for pulse_swallow_ctrl plus short
//            hand-written sequences for enable loss and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_swallow_ctrl;

  localparam int CW = 8;
  localparam int OW = 4 + 2 * CW;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          presc_tick;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_p;
  logic [CW-1:0] cfg_s;
  logic          mc;
  logic          frame_pulse;
  logic [CW-1:0] p_count;
  logic [CW-1:0] s_count;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          en;
    logic          tick;
    logic          vld;
    logic [CW-1:0] p;
    logic [CW-1:0] s;
    logic          e_mc;
    logic          e_fp;
    logic [CW-1:0] e_pc;
    logic [CW-1:0] e_sc;
    logic          e_rdy;
    logic          e_err;
  } vec_t;

  vec_t vq[$];

  pulse_swallow_ctrl #(
    .CW (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .presc_tick  (presc_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_p       (cfg_p),
    .cfg_s       (cfg_s),
    .mc          (mc),
    .frame_pulse (frame_pulse),
    .p_count     (p_count),
    .s_count     (s_count),
    .cfg_err     (cfg_err)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [OW-1:0] outs();
    return {mc, frame_pulse, p_count, s_count, cfg_ready, cfg_err};
  endfunction

  function automatic logic [OW-1:0] pack(input logic m, input logic f,
                                          input int pc, input int sc,
                                          input logic r, input logic e);
    return {m, f, CW'(pc), CW'(sc), r, e};
  endfunction

  task automatic check(input string name, input logic [OW-1:0] exp);
    logic [OW-1:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {mc,fp,pc,sc,rdy,err}=%b_%b_%0d_%0d_%b_%b required %b_%b_%0d_%0d_%b_%b",
               name, act[OW-1], act[OW-2], act[2*CW+1:CW+2], act[CW+1:2], act[1], act[0],
               exp[OW-1], exp[OW-2], exp[2*CW+1:CW+2], exp[CW+1:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // en tick vld P S | mc fp pc sc rdy err  (expected after the next edge)
  task automatic add(input logic en, input logic tk, input logic v, input int p, input int s,
                     input logic m, input logic f, input int pc, input int sc,
                     input logic r, input logic e);
    vq.push_back('{en, tk, v, CW'(p), CW'(s), m, f, CW'(pc), CW'(sc), r, e});
  endtask

  initial begin
    // No config yet: ticks ignored in IDLE
    add(1,1,0,0,0, 0,0,0,0,1,0);
    // P=4,S=1 accepted, loaded on the following edge
    add(1,0,1,4,1, 0,0,0,0,0,0);
    add(1,0,0,0,0, 1,0,4,1,1,0);
    add(1,0,0,0,0, 1,0,4,1,1,0);
    add(1,1,0,0,0, 0,0,3,0,1,0);
    add(1,0,0,0,0, 0,0,3,0,1,0);
    add(1,1,0,0,0, 0,0,2,0,1,0);
    add(1,1,0,0,0, 0,0,1,0,1,0);
    add(1,1,0,0,0, 1,1,4,1,1,0);
    add(1,0,0,0,0, 1,0,4,1,1,0);
    // Illegal offers: consumed, cfg_err pulses, active unchanged
    add(1,0,1,0,0, 1,0,4,1,1,1);
    add(1,0,1,2,5, 1,0,4,1,1,1);
    add(1,0,0,0,0, 1,0,4,1,1,0);
    add(1,1,0,0,0, 0,0,3,0,1,0);
    add(1,1,0,0,0, 0,0,2,0,1,0);
    add(1,1,0,0,0, 0,0,1,0,1,0);
    add(1,1,0,0,0, 1,1,4,1,1,0);
    // P=5,S=2 offered mid-frame: waits for the boundary
    add(1,0,1,5,2, 1,0,4,1,0,0);
    add(1,1,0,0,0, 0,0,3,0,0,0);
    add(1,1,0,0,0, 0,0,2,0,0,0);
    add(1,1,0,0,0, 0,0,1,0,0,0);
    add(1,1,0,0,0, 1,1,5,2,1,0);
    add(1,1,0,0,0, 1,0,4,1,1,0);
    add(1,1,0,0,0, 0,0,3,0,1,0);
    add(1,1,0,0,0, 0,0,2,0,1,0);
    add(1,1,0,0,0, 0,0,1,0,1,0);
    add(1,1,0,0,0, 1,1,5,2,1,0);
    // P=3,S=3: /3 for the whole frame
    add(1,0,1,3,3, 1,0,5,2,0,0);
    add(1,1,0,0,0, 1,0,4,1,0,0);
    add(1,1,0,0,0, 0,0,3,0,0,0);
    add(1,1,0,0,0, 0,0,2,0,0,0);
    add(1,1,0,0,0, 0,0,1,0,0,0);
    add(1,1,0,0,0, 1,1,3,3,1,0);
    add(1,1,0,0,0, 1,0,2,2,1,0);
    add(1,1,0,0,0, 1,0,1,1,1,0);
    add(1,1,0,0,0, 1,1,3,3,1,0);
    // P=2,S=0: /2 throughout, frame every 2 ticks
    add(1,1,1,2,0, 1,0,2,2,0,0);
    add(1,1,0,0,0, 1,0,1,1,0,0);
    add(1,1,0,0,0, 0,1,2,0,1,0);
    add(1,1,0,0,0, 0,0,1,0,1,0);
    add(1,1,0,0,0, 0,1,2,0,1,0);
    add(1,0,0,0,0, 0,0,2,0,1,0);
    // Config accepted on a frame-end edge applies one frame later
    add(1,1,0,0,0, 0,0,1,0,1,0);
    add(1,1,1,4,1, 0,1,2,0,0,0);
    add(1,1,0,0,0, 0,0,1,0,0,0);
    add(1,1,0,0,0, 1,1,4,1,1,0);
  end

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    presc_tick = 1'b0;
    cfg_valid  = 1'b0;
    cfg_p      = '0;
    cfg_s      = '0;
    step();
    step();
    check("reset_state", pack(0,0,0,0,1,0));
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      enable     = vq[i].en;
      presc_tick = vq[i].tick;
      cfg_valid  = vq[i].vld;
      cfg_p      = vq[i].p;
      cfg_s      = vq[i].s;
      step();
      check($sformatf("vec%0d", i),
            {vq[i].e_mc, vq[i].e_fp, vq[i].e_pc, vq[i].e_sc, vq[i].e_rdy, vq[i].e_err});
    end

    // Enable loss mid-SWALLOW (P=4,S=1 frame just loaded)
    cfg_valid  = 1'b0;
    enable     = 1'b0;
    presc_tick = 1'b0;
    step();
    check("enable_off", pack(0,0,0,0,1,0));
    presc_tick = 1'b1;
    step();
    check("enable_off_tick", pack(0,0,0,0,1,0));
    enable     = 1'b1;
    presc_tick = 1'b0;
    step();
    check("reenable_reload", pack(1,0,4,1,1,0));
    presc_tick = 1'b1;
    step();
    check("reenable_tick", pack(0,0,3,0,1,0));

    // Asynchronous reset mid-cycle, no clock edge involved
    presc_tick = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    check("async_reset", pack(0,0,0,0,1,0));
    #1;
    reset = 1'b1;
    presc_tick = 1'b1;
    step();
    step();
    check("post_reset_idle", pack(0,0,0,0,1,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_swallow_ctrl
`default_nettype wire
